// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: deframes scan codes, tracks E0/F0 prefixes, holds the current make code.
// Latency: key_valid/frame_err pulse 1 Clk after the STOP-bit fall (plus sync + filter delay from the pin).
// Backpressure: none; the keyboard cannot be stalled, so every decoded byte is acted on immediately.
//
// Ports:
//   Clk, Reset_h         system clock, synchronous active-high reset
//   PS2_CLK, PS2_DAT     raw asynchronous keyboard lines (idle high), input only
//   keycode[7:0]         held make code, 8'h00 when no key is held
//   keycode_ext          held key was E0-prefixed
//   key_valid            1-cycle pulse when keycode/keycode_ext are written
//   frame_err            1-cycle pulse on parity/stop error or mid-frame timeout
module ps2_keycode_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       Clk,
  input  logic       Reset_h,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keycode,
  output logic       keycode_ext,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_s;
  logic                   dat_s;
  logic                   clk_flt;
  logic                   clk_flt_d;
  logic [FW-1:0]          flt_cnt;
  logic                   fall;

  state_t                 state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par;
  logic                   byte_done;
  logic                   byte_ok;
  logic                   ext_pend;
  logic                   brk_pend;
  logic [TW-1:0]          tcnt;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall  = clk_flt_d & ~clk_flt;

  // Synchronizers and glitch filter. The filtered clock only follows the
  // synced clock after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      clk_sync  <= '1;
      dat_sync  <= '1;
      clk_flt   <= 1'b1;
      clk_flt_d <= 1'b1;
      flt_cnt   <= '0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
      clk_flt_d <= clk_flt;
      if (clk_s == clk_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_flt <= clk_s;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  // Frame FSM, timeout watchdog and prefix/keycode bookkeeping.
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      byte_done   <= 1'b0;
      byte_ok     <= 1'b0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      tcnt        <= '0;
      keycode     <= '0;
      keycode_ext <= 1'b0;
      key_valid   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      byte_done <= 1'b0;

      if (fall || state == IDLE) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end

      if (fall) begin
        unique case (state)
          IDLE: begin
            // A high data bit on a fall is a false start; stay idle.
            if (!dat_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat_s;
            state <= STOP;
          end
          STOP: begin
            byte_done <= 1'b1;
            byte_ok   <= dat_s & (^{shreg, par});
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYC)) begin
        // Keyboard stopped clocking mid-frame: abandon the frame and any
        // prefix context it may have belonged to.
        state     <= IDLE;
        frame_err <= 1'b1;
        ext_pend  <= 1'b0;
        brk_pend  <= 1'b0;
      end

      // byte_done is only ever set while returning to IDLE, so it never
      // coincides with a timeout abort.
      if (byte_done) begin
        if (!byte_ok) begin
          frame_err <= 1'b1;
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
        end else if (shreg == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          if (!brk_pend) begin
            keycode     <= shreg;
            keycode_ext <= ext_pend;
            key_valid   <= 1'b1;
          end else if (shreg == keycode && ext_pend == keycode_ext) begin
            // Only the break of the currently held key releases it.
            keycode     <= '0;
            keycode_ext <= 1'b0;
            key_valid   <= 1'b1;
          end
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
module tb_ps2_keycode_rx;

  logic       Clk;
  logic       Reset_h;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] keycode;
  logic       keycode_ext;
  logic       key_valid;
  logic       frame_err;

  ps2_keycode_rx #(
    .SYNC_STAGES(2),
    .FILTER_LEN (2),
    .TIMEOUT_CYC(200)
  ) dut (
    .Clk        (Clk),
    .Reset_h    (Reset_h),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .keycode    (keycode),
    .keycode_ext(keycode_ext),
    .key_valid  (key_valid),
    .frame_err  (frame_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total;
  int passed;

  // Pulse monitor, sampled on the falling Clk edge.
  int         kv_cnt;
  int         fe_cnt;
  int         both_cnt;
  logic [8:0] last_kv;
  int         kv_seen;
  int         fe_seen;

  initial begin
    kv_cnt   = 0;
    fe_cnt   = 0;
    both_cnt = 0;
    last_kv  = '0;
  end

  always @(negedge Clk) begin
    if (key_valid) begin
      kv_cnt  = kv_cnt + 1;
      last_kv = {keycode_ext, keycode};
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (key_valid && frame_err) both_cnt = both_cnt + 1;
  end

  // Reference model: keyboard protocol rules applied byte by byte.
  logic [7:0] m_key;
  logic       m_ext;
  bit         m_ep;
  bit         m_bp;
  int         m_kv;
  int         m_fe;

  task automatic model_reset();
    m_key = 8'h00; m_ext = 1'b0; m_ep = 0; m_bp = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    m_kv = 0;
    m_fe = 0;
    if (!ok) begin
      m_fe = 1; m_ep = 0; m_bp = 0;
    end else if (b == 8'hE0) begin
      m_ep = 1;
    end else if (b == 8'hF0) begin
      m_bp = 1;
    end else begin
      if (!m_bp) begin
        m_key = b; m_ext = m_ep; m_kv = 1;
      end else if (b == m_key && m_ep == m_ext) begin
        m_key = 8'h00; m_ext = 1'b0; m_kv = 1;
      end
      m_ep = 0;
      m_bp = 0;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic frame_check(input string nm, input logic [7:0] ekey, input logic eext,
                             input int ekv, input int efe);
    chk({nm, "_key"}, int'(keycode), int'(ekey));
    chk({nm, "_ext"}, int'(keycode_ext), int'(eext));
    chk({nm, "_kv_pulses"}, kv_cnt - kv_seen, ekv);
    chk({nm, "_fe_pulses"}, fe_cnt - fe_seen, efe);
    if (ekv == 1 && kv_cnt - kv_seen == 1)
      chk({nm, "_kv_value"}, int'(last_kv), int'({eext, ekey}));
    kv_seen = kv_cnt;
    fe_seen = fe_cnt;
  endtask

  // Bits go out LSB first; data changes mid-high, keyboard clock 20 Clk per half.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      PS2_DAT = bits[i];
      repeat (10) @(negedge Clk);
      PS2_CLK = 1'b0;
      repeat (20) @(negedge Clk);
      PS2_CLK = 1'b1;
      repeat (10) @(negedge Clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic p;
    logic s;
    p = (~^d) ^ bad_par;
    s = ~bad_stop;
    send_bits({s, p, d, 1'b0}, 11);
    PS2_DAT = 1'b1;
    repeat (30) @(negedge Clk);
  endtask

  typedef struct {
    logic [7:0] dat;
    bit         bad_par;
    bit         bad_stop;
    logic [7:0] exp_key;
    logic       exp_ext;
    int         exp_kv;
    int         exp_fe;
  } vec_t;

  vec_t       vecs[27];
  logic [7:0] pool[8];

  initial begin
    logic [7:0] b;
    int         r;
    bit         bad;

    total   = 0;
    passed  = 0;
    kv_seen = 0;
    fe_seen = 0;

    vecs = '{
      '{8'h23, 0, 0, 8'h23, 1'b0, 1, 0},  // make D
      '{8'hF0, 0, 0, 8'h23, 1'b0, 0, 0},  // break prefix: silent
      '{8'h23, 0, 0, 8'h00, 1'b0, 1, 0},  // D released
      '{8'hE0, 0, 0, 8'h00, 1'b0, 0, 0},
      '{8'h75, 0, 0, 8'h75, 1'b1, 1, 0},  // extended make
      '{8'hE0, 0, 0, 8'h75, 1'b1, 0, 0},
      '{8'hF0, 0, 0, 8'h75, 1'b1, 0, 0},
      '{8'h75, 0, 0, 8'h00, 1'b0, 1, 0},  // extended break
      '{8'h1D, 0, 0, 8'h1D, 1'b0, 1, 0},
      '{8'h1C, 1, 0, 8'h1D, 1'b0, 0, 1},  // parity error
      '{8'h1C, 0, 1, 8'h1D, 1'b0, 0, 1},  // stop error
      '{8'h1D, 0, 0, 8'h1D, 1'b0, 1, 0},  // typematic repeat
      '{8'h24, 0, 0, 8'h24, 1'b0, 1, 0},  // last key wins
      '{8'hF0, 0, 0, 8'h24, 1'b0, 0, 0},
      '{8'h1D, 0, 0, 8'h24, 1'b0, 0, 0},  // break of older key ignored
      '{8'hE0, 0, 0, 8'h24, 1'b0, 0, 0},
      '{8'hF0, 0, 0, 8'h24, 1'b0, 0, 0},
      '{8'h24, 0, 0, 8'h24, 1'b0, 0, 0},  // ext mismatch: no release
      '{8'hF0, 0, 0, 8'h24, 1'b0, 0, 0},
      '{8'h24, 0, 0, 8'h00, 1'b0, 1, 0},  // pending flags were cleared
      '{8'hE0, 0, 0, 8'h00, 1'b0, 0, 0},
      '{8'h1C, 1, 0, 8'h00, 1'b0, 0, 1},  // error clears E0
      '{8'h24, 0, 0, 8'h24, 1'b0, 1, 0},  // so this is non-extended
      '{8'hE0, 0, 0, 8'h24, 1'b0, 0, 0},
      '{8'h75, 0, 0, 8'h75, 1'b1, 1, 0},
      '{8'hF0, 0, 0, 8'h75, 1'b1, 0, 0},
      '{8'h75, 0, 0, 8'h75, 1'b1, 0, 0}   // plain break vs extended hold
    };
    pool = '{8'h1C, 8'h1D, 8'h23, 8'h24, 8'h75, 8'h6B, 8'h74, 8'h72};

    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    Reset_h = 1'b1;
    repeat (5) @(negedge Clk);
    Reset_h = 1'b0;
    model_reset();
    @(negedge Clk);
    chk("reset_key", int'(keycode), 0);
    chk("reset_ext", int'(keycode_ext), 0);
    chk("reset_kv", int'(key_valid), 0);
    chk("reset_fe", int'(frame_err), 0);
    repeat (20) @(negedge Clk);
    kv_seen = kv_cnt;
    fe_seen = fe_cnt;

    // Directed table.
    for (int i = 0; i < 27; i++) begin
      send_frame(vecs[i].dat, vecs[i].bad_par, vecs[i].bad_stop);
      model_byte(vecs[i].dat, !(vecs[i].bad_par || vecs[i].bad_stop));
      frame_check($sformatf("vec%0d", i), vecs[i].exp_key, vecs[i].exp_ext,
                  vecs[i].exp_kv, vecs[i].exp_fe);
    end

    // Timeout: a pending F0 must be discarded, so the following 1D is a make.
    send_frame(8'h1D, 0, 0);
    frame_check("to_make", 8'h1D, 1'b0, 1, 0);
    send_frame(8'hF0, 0, 0);
    frame_check("to_f0", 8'h1D, 1'b0, 0, 0);
    send_bits({3'b111, 8'h1D, 1'b0}, 5);
    PS2_DAT = 1'b1;
    repeat (300) @(negedge Clk);
    frame_check("timeout", 8'h1D, 1'b0, 0, 1);
    send_frame(8'h1D, 0, 0);
    frame_check("after_to", 8'h1D, 1'b0, 1, 0);
    model_reset();
    m_key = 8'h1D;

    // Reset in the middle of a frame.
    send_frame(8'h23, 0, 0);
    frame_check("pre_rst", 8'h23, 1'b0, 1, 0);
    send_bits({3'b111, 8'h1B, 1'b0}, 6);
    @(negedge Clk);
    Reset_h = 1'b1;
    @(negedge Clk);
    Reset_h = 1'b0;
    chk("midrst_key", int'(keycode), 0);
    chk("midrst_ext", int'(keycode_ext), 0);
    chk("midrst_kv", int'(key_valid), 0);
    chk("midrst_fe", int'(frame_err), 0);
    PS2_DAT = 1'b1;
    repeat (300) @(negedge Clk);
    frame_check("post_rst_idle", 8'h00, 1'b0, 0, 0);
    model_reset();
    send_frame(8'h1B, 0, 0);
    model_byte(8'h1B, 1);
    frame_check("post_rst", 8'h1B, 1'b0, 1, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      r   = $urandom_range(0, 9);
      bad = 0;
      if (r <= 1)      b = 8'hE0;
      else if (r <= 3) b = 8'hF0;
      else if (r == 4) begin b = 8'($urandom_range(0, 255)); bad = 1; end
      else if (r <= 6 && m_key != 8'h00) b = m_key;
      else             b = pool[$urandom_range(0, 7)];
      send_frame(b, bad, 0);
      model_byte(b, !bad);
      frame_check($sformatf("rnd%0d_%02h", i, b), m_key, m_ext, m_kv, m_fe);
    end

    chk("kv_fe_overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
